// File: rtl/cpu_memory_responder.sv
// Memory-side responder for the 8-bit CPU bus: 256-byte synchronous RAM with a byte-stream loader that holds the CPU in reset.
// Optional memory-mapped I/O port at IO_ADDR is enabled by defining MEM_IO_PORT_EN.
module cpu_memory_responder #(
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 8,
    parameter logic [ADDR_W-1:0] IO_ADDR = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] to_memory,
    input  logic              write,
    output logic [DATA_W-1:0] from_memory,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              load_start,
    output logic              cpu_hold,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              load_accept;
    logic              io_hit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    assign load_ready  = (state == LOAD);
    assign cpu_hold    = (state == LOAD);
    assign load_accept = load_valid && load_ready;

`ifdef MEM_IO_PORT_EN
    assign io_hit = (address == IO_ADDR);
`else
    logic unused_io;
    assign io_hit    = 1'b0;
    assign unused_io = ^{in_port, IO_ADDR};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_wa     = address;
        mem_wd     = to_memory;
        case (state)
            LOAD: begin
                mem_wa = ptr;
                mem_wd = load_data;
                mem_we = load_accept;
                // Either an explicit last byte or filling the final location ends the load.
                if (load_accept && (load_last || ptr == '1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_we = write && !io_hit;
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (state == LOAD) begin
            if (load_accept) begin
                ptr <= ptr + 1'b1;
            end
        end else if (load_start) begin
            ptr <= '0;
        end
    end

    // RAM contents deliberately survive reset so a partial load is still visible.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            from_memory <= '0;
        end else if (state == LOAD || load_start) begin
            from_memory <= '0;
        end else if (io_hit) begin
            from_memory <= in_port;
        end else if (write) begin
            from_memory <= to_memory;
        end else begin
            from_memory <= mem[address];
        end
    end

`ifdef MEM_IO_PORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_port <= '0;
        end else if (state == RUN && write && io_hit) begin
            out_port <= to_memory;
        end
    end
`else
    assign out_port = '0;
`endif

endmodule
